fetch_queue: RTL



---
 rtl/mips_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared widths, reset PC and the FIFO entry type for the
// instruction-fetch front end.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued fetch: the instruction word and the address of the next word.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch entries.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - synchronous flush (pointers and count to zero)
//   push, push_data - write one entry at the tail
//   pop         - drop the head entry
//   head        - registered head entry (storage read, no input-to-output path)
//   count       - number of valid entries
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against pushing into a full buffer or popping an empty one; the
  // pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end of the pipelined MIPS core.
// Owns the fetch PC, issues word addresses to a 1-cycle-latency instruction
// memory, buffers {instr, pc4} in a FIFO and presents the head to IF/ID.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   imem_req, imem_addr      - fetch request and word-aligned byte address
//   imem_rdata, imem_rvalid  - instruction returned one cycle after a request
//   redirect, redirect_pc    - branch/jump pulse and its target
//   out_valid, out_instr, out_pc4, out_ready - handshake towards IF/ID
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc4,
  input  logic               out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc4_q, inflight_pc4_d;
  logic              inflight_q, inflight_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              epoch_q, epoch_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_push;
  logic              fifo_pop;
  fetch_entry_t      fifo_in;
  fetch_entry_t      fifo_head;

  // Queued entries plus the outstanding response must fit, so a response can
  // always be accepted. Gating with rst_n keeps the request low in reset.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req  = rst_n && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // A response is kept only if it belongs to the current epoch and no
  // redirect is flushing the queue in this very cycle.
  assign fifo_push = imem_rvalid && inflight_q && !redirect &&
                     (inflight_epoch_q == epoch_q);
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_in   = '{instr: imem_rdata, pc4: inflight_pc4_q};

  // Redirect takes priority over issue: new PC (word aligned), flip epoch.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_pc4_d   = inflight_pc4_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;
    inflight_d       = imem_req;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      epoch_d    = ~epoch_q;
    end else if (imem_req) begin
      fetch_pc_d       = fetch_pc_q + 32'd4;
      inflight_pc4_d   = fetch_pc_q + 32'd4;
      inflight_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc4_q   <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc4_q   <= inflight_pc4_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_instr = fifo_head.instr;
  assign out_pc4   = fifo_head.pc4;

endmodule
